// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset control FSM and the datapath muxes.
package multicycle_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;

  typedef enum logic [SEL_W-1:0] {
    ALU_ADD    = 2'd0,
    ALU_BRANCH = 2'd1,
    ALU_FUNCT  = 2'd2
  } alu_op_e;

  typedef enum logic [SEL_W-1:0] {
    SRC_A_PC     = 2'd0,
    SRC_A_RS1    = 2'd1,
    SRC_A_OLD_PC = 2'd2
  } src_a_e;

  typedef enum logic [SEL_W-1:0] {
    SRC_B_RS2  = 2'd0,
    SRC_B_FOUR = 2'd1,
    SRC_B_IMM  = 2'd2
  } src_b_e;

  typedef enum logic [SEL_W-1:0] {
    WB_ALUOUT = 2'd0,
    WB_MDR    = 2'd1,
    WB_PC     = 2'd2
  } wb_sel_e;

  // Step that follows DECODE; unsupported opcodes fall back to FETCH.
  function automatic state_e decode_next(logic [OPC_W-1:0] opcode);
    case (opcode)
      OP_R:               return S_EXEC_R;
      OP_I:               return S_EXEC_I;
      OP_LOAD, OP_STORE:  return S_MEM_ADDR;
      OP_BRANCH:          return S_BRANCH;
      OP_JAL:             return S_JAL;
      default:            return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle controller (master) and the datapath (slave).
interface multicycle_ctrl_if;
  import multicycle_pkg::*;

  logic [OPC_W-1:0] opcode_i;
  logic             branch_taken_i;
  logic             mem_ready_i;
  logic             mem_req_o;
  logic             mem_we_o;
  logic             iord_o;
  logic             ir_write_o;
  logic             pc_write_o;
  logic             pc_src_o;
  logic [SEL_W-1:0] alu_src_a_o;
  logic [SEL_W-1:0] alu_src_b_o;
  logic [SEL_W-1:0] alu_op_o;
  logic             target_write_o;
  logic             reg_write_o;
  logic [SEL_W-1:0] wb_sel_o;
  logic             illegal_o;

  modport master (
    input  opcode_i, branch_taken_i, mem_ready_i,
    output mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, target_write_o, reg_write_o,
           wb_sel_o, illegal_o
  );

  modport slave (
    output opcode_i, branch_taken_i, mem_ready_i,
    input  mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, target_write_o, reg_write_o,
           wb_sel_o, illegal_o
  );
endinterface

// File: rtl/multicycle_perf_cnt.sv
// Cycle and retired-instruction counters for the multi-cycle controller; both wrap.
module multicycle_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             retire_i,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instret_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_cnt_o <= '0;
      instret_o   <= '0;
    end else begin
      cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
      if (retire_i) instret_o <= instret_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle CPU: sequences fetch/decode/execute/memory/write-back.
// Define MULTICYCLE_PERF_CNT_EN to build the cycle/instret counters; otherwise they read 0.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  multicycle_ctrl_if.master     bus,
  output logic [STATE_W-1:0]    state_o,
  output logic [CNT_W-1:0]      cycle_cnt_o,
  output logic [CNT_W-1:0]      instret_o
);

  state_e state;

  // Memory states hold until the port reports ready; everything else advances every cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (bus.mem_ready_i) state <= S_DECODE;
        S_DECODE:   state <= decode_next(bus.opcode_i);
        S_EXEC_R,
        S_EXEC_I:   state <= S_ALU_WB;
        S_MEM_ADDR: state <= (bus.opcode_i == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (bus.mem_ready_i) state <= S_MEM_WB;
        S_MEM_WR:   if (bus.mem_ready_i) state <= S_FETCH;
        default:    state <= S_FETCH;
      endcase
    end
  end

  assign state_o = state;

  // Moore decode of the datapath controls; everything is held low while reset is asserted.
  always_comb begin
    bus.mem_req_o      = 1'b0;
    bus.mem_we_o       = 1'b0;
    bus.iord_o         = 1'b0;
    bus.ir_write_o     = 1'b0;
    bus.pc_write_o     = 1'b0;
    bus.pc_src_o       = 1'b0;
    bus.alu_src_a_o    = SRC_A_PC;
    bus.alu_src_b_o    = SRC_B_RS2;
    bus.alu_op_o       = ALU_ADD;
    bus.target_write_o = 1'b0;
    bus.reg_write_o    = 1'b0;
    bus.wb_sel_o       = WB_ALUOUT;
    bus.illegal_o      = 1'b0;
    if (!rst_i) begin
      case (state)
        S_FETCH: begin
          bus.mem_req_o   = 1'b1;
          bus.alu_src_b_o = SRC_B_FOUR;
          bus.ir_write_o  = bus.mem_ready_i;
          bus.pc_write_o  = bus.mem_ready_i;
        end
        S_DECODE: begin
          bus.alu_src_a_o    = SRC_A_OLD_PC;
          bus.alu_src_b_o    = SRC_B_IMM;
          bus.target_write_o = 1'b1;
          bus.illegal_o      = (decode_next(bus.opcode_i) == S_FETCH);
        end
        S_EXEC_R: begin
          bus.alu_src_a_o = SRC_A_RS1;
          bus.alu_src_b_o = SRC_B_RS2;
          bus.alu_op_o    = ALU_FUNCT;
        end
        S_EXEC_I: begin
          bus.alu_src_a_o = SRC_A_RS1;
          bus.alu_src_b_o = SRC_B_IMM;
          bus.alu_op_o    = ALU_FUNCT;
        end
        S_ALU_WB: bus.reg_write_o = 1'b1;
        S_MEM_ADDR: begin
          bus.alu_src_a_o = SRC_A_RS1;
          bus.alu_src_b_o = SRC_B_IMM;
        end
        S_MEM_RD: begin
          bus.mem_req_o = 1'b1;
          bus.iord_o    = 1'b1;
        end
        S_MEM_WB: begin
          bus.reg_write_o = 1'b1;
          bus.wb_sel_o    = WB_MDR;
        end
        S_MEM_WR: begin
          bus.mem_req_o = 1'b1;
          bus.mem_we_o  = 1'b1;
          bus.iord_o    = 1'b1;
        end
        S_BRANCH: begin
          bus.alu_src_a_o = SRC_A_RS1;
          bus.alu_src_b_o = SRC_B_RS2;
          bus.alu_op_o    = ALU_BRANCH;
          bus.pc_src_o    = 1'b1;
          bus.pc_write_o  = bus.branch_taken_i;
        end
        S_JAL: begin
          bus.reg_write_o = 1'b1;
          bus.wb_sel_o    = WB_PC;
          bus.pc_write_o  = 1'b1;
          bus.pc_src_o    = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MULTICYCLE_PERF_CNT_EN
  logic retire;

  // Last cycle of every legal instruction.
  always_comb begin
    retire = 1'b0;
    if (!rst_i) begin
      case (state)
        S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL: retire = 1'b1;
        S_MEM_WR:                            retire = bus.mem_ready_i;
        default:                             retire = 1'b0;
      endcase
    end
  end

  multicycle_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .retire_i    (retire),
    .cycle_cnt_o (cycle_cnt_o),
    .instret_o   (instret_o)
  );
`else
  assign cycle_cnt_o = '0;
  assign instret_o   = '0;
`endif

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle RV32I-subset CPU. Sequences the shared datapath (one ALU, one unified memory port, register file, IR/PC registers) through fetch, decode, execute, memory and write-back steps, driving the mux selects and write enables each cycle. Handles a ready/request handshake on the memory port so memory may insert wait states. Sits between the instruction register and the datapath, replacing the combinational single-cycle decoder.

## Interface
- `CNT_W`, default 32: width of the performance counters.

- `clk_i` input 1: clock; all state changes on the rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `opcode_i` input 7: IR[6:0]; valid from the DECODE state on.
- `branch_taken_i` input 1: branch comparison result from the ALU/compare unit.
- `mem_ready_i` input 1: memory completes the current access this cycle.
- `mem_req_o` output 1: memory access request.
- `mem_we_o` output 1: write (1) or read (0).
- `iord_o` output 1: address select, 0 = PC, 1 = ALUOut.
- `ir_write_o` output 1: load the IR from memory read data.
- `pc_write_o` output 1: load the PC.
- `pc_src_o` output 1: 0 = ALU result (PC+4), 1 = target register.
- `alu_src_a_o` output 2: 0 = PC, 1 = rs1, 2 = old PC.
- `alu_src_b_o` output 2: 0 = rs2, 1 = constant 4, 2 = immediate.
- `alu_op_o` output 2: 00 = add, 01 = branch compare, 10 = decode by funct.
- `target_write_o` output 1: latch the ALU result as the branch/jump target.
- `reg_write_o` output 1: register file write enable.
- `wb_sel_o` output 2: 0 = ALUOut, 1 = MDR, 2 = PC (link).
- `illegal_o` output 1: one-cycle pulse on an unsupported opcode.
- `state_o` output 4: current state, for debug.
- `cycle_cnt_o` output CNT_W: cycle counter.
- `instret_o` output CNT_W: retired-instruction counter.

## Operation
- Outputs are Moore-decoded from the state. Exception: the `pc_write_o`/`ir_write_o` strobes are gated by `mem_ready_i` or `branch_taken_i` as listed below. Any output not listed for a state is 0.
- **FETCH**: `mem_req_o`=1, `iord_o`=0, `alu_src_a_o`=PC, `alu_src_b_o`=4, `alu_op_o`=00. While `mem_ready_i`=0, hold. When `mem_ready_i`=1: `ir_write_o`=1, `pc_write_o`=1, `pc_src_o`=0, then go to DECODE.
- **DECODE**: `alu_src_a_o`=old PC, `alu_src_b_o`=imm, `alu_op_o`=00, `target_write_o`=1. Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - any other opcode → FETCH with `illegal_o`=1. No architectural write occurs.
- **EXEC_R**: src_a=rs1, src_b=rs2, op=10, then ALU_WB.
- **EXEC_I**: src_a=rs1, src_b=imm, op=10, then ALU_WB.
- **ALU_WB**: `reg_write_o`=1, `wb_sel_o`=0, then FETCH.
- **MEM_ADDR**: src_a=rs1, src_b=imm, op=00. Load goes to MEM_RD; store goes to MEM_WR.
- **MEM_RD**: `mem_req_o`=1, `iord_o`=1, `mem_we_o`=0. Hold until `mem_ready_i`, then MEM_WB.
- **MEM_WB**: `reg_write_o`=1, `wb_sel_o`=1, then FETCH.
- **MEM_WR**: `mem_req_o`=1, `mem_we_o`=1, `iord_o`=1. Hold until `mem_ready_i`, then FETCH.
- **BRANCH**: src_a=rs1, src_b=rs2, op=01. `pc_src_o`=1 and `pc_write_o`=`branch_taken_i`. Then FETCH.
- **JAL**: `reg_write_o`=1, `wb_sel_o`=2, `pc_write_o`=1, `pc_src_o`=1, then FETCH.
- `mem_ready_i` is ignored when `mem_req_o`=0.
- An instruction retires on the exit cycle of ALU_WB, MEM_WB, MEM_WR (with ready), BRANCH or JAL. An illegal instruction does not retire.

## Timing
- Reset: state=FETCH, `state_o`=0, counters=0. `mem_req_o`=1 from the first cycle after reset; all strobes are 0 during reset.
- With zero-wait memory:
  - R-type and I-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch and JAL: 3 cycles.
  - Illegal opcode: 2 cycles.
- Each wait cycle on FETCH, MEM_RD or MEM_WR adds exactly 1 cycle.
- `mem_req_o`, `mem_we_o` and `iord_o` stay stable for the whole wait period.
- Reset mid-operation (including while `mem_req_o`=1 and waiting): on the next edge the state is FETCH. No write strobe is asserted in the reset cycle.

## Configuration
- `MULTICYCLE_PERF_CNT_EN` defined:
  - `cycle_cnt_o` increments every non-reset cycle.
  - `instret_o` increments on each retire cycle.
  - Both wrap modulo 2^CNT_W.
- Not defined: both ports are tied to 0 and no counter flops are synthesized.

## Structure
- `multicycle_pkg` holds:
  - the state enum (4-bit encoding, FETCH=0);
  - opcode constants;
  - the ALUOp, `alu_src_a`/`alu_src_b` and `wb_sel` encodings.

  The datapath muxes import the same package.
- Sub-module `multicycle_perf_cnt` holds the two counters. It is instantiated only under the macro.

## Test plan
- Zero-wait memory; R-type `add` (opcode 0110011): state sequence FETCH→DECODE→EXEC_R→ALU_WB→FETCH. `reg_write_o`=1 in exactly cycle 4, with `wb_sel_o`=0.
- Load with `mem_ready_i` low for 2 cycles in both FETCH and MEM_RD: total 9 cycles; `mem_req_o` held steady; `ir_write_o` pulses once.
- Branch with `branch_taken_i`=1, then a second branch with 0: `pc_write_o`=1 with `pc_src_o`=1 in the first BRANCH cycle; `pc_write_o`=0 in the second.
- Opcode 0000000: `illegal_o`=1 for one cycle in DECODE; next state FETCH; no `reg_write_o` or `mem_we_o`; `instret_o` unchanged.
- Assert `rst_i` during the MEM_WR wait: next cycle is FETCH with `mem_we_o`=0 and counters=0.
- With the macro defined, run 10 zero-wait R-type instructions from reset: `instret_o`=10 and `cycle_cnt_o`=40.
